hw_deque: RTL and testbench

Parametrised synthesizable double-ended queue. It gives testbench-style queue behaviour (push_front, push_back, pop_front, pop_back, indexed peek) to RTL datapaths. Storage is a circular buffer of DEPTH words of WIDTH bits, with one operation per cycle over a valid/ready handshake. It sits between a producer/consumer pair that needs LIFO and FIFO access to the same buffer, for example retry or replay logic.

---
 rtl/hw_deque.sv | 147 ++++++++++++++
 tb/tb_hw_deque.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_deque.sv
// hw_deque: parametrised double-ended queue on a circular buffer.
//
// Offers push_back / push_front / pop_back / pop_front with one accepted
// operation per cycle, plus combinational views of the front and back entries.
// Storage is DEPTH words of WIDTH bits; DEPTH need not be a power of two.
//
// Optional feature macro: HW_DEQUE_PEEK_EN
//   When defined, adds rd_idx/rd_data, which give a combinational indexed peek
//   at logical position rd_idx (0 = front). Reads never change state.
//
// Ports:
//   clk        rising-edge clock
//   rst_l      asynchronous active-low reset
//   op_valid   request present
//   op         00 push_back, 01 push_front, 10 pop_back, 11 pop_front
//   op_data    push data
//   op_ready   request can be accepted this cycle (combinational on op + state)
//   rsp_valid  one-cycle pulse, the cycle after an accepted pop
//   rsp_data   last popped word, held until the next pop
//   front_data logical index 0, 0 when empty
//   back_data  logical index count-1, 0 when empty
//   count      number of stored entries
//   full       count == DEPTH
//   empty      count == 0
//   rd_idx     (HW_DEQUE_PEEK_EN) logical peek index
//   rd_data    (HW_DEQUE_PEEK_EN) peeked word, 0 when rd_idx >= count
//
// Handshake: a request transfers on a rising clk edge where op_valid and
// op_ready are both high. A requester that sees op_ready low keeps its request
// stable until it is taken; nothing is dropped and no error is flagged. There
// is no backpressure on the response side.
module hw_deque #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] front_data,
  output logic [WIDTH-1:0] back_data,
  output logic [CW-1:0]    count,
`ifdef HW_DEQUE_PEEK_EN
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
`endif
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] OP_PUSH_BACK  = 2'b00;
  localparam logic [1:0] OP_PUSH_FRONT = 2'b01;
  localparam logic [1:0] OP_POP_BACK   = 2'b10;
  localparam logic [1:0] OP_POP_FRONT  = 2'b11;

  // One extra bit so head + offset (< 2*DEPTH) never overflows before the wrap.
  localparam int SW = CW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    head;

  // Physical slot of logical offset off from head. A single compare-and-
  // subtract is enough because head < DEPTH and off <= DEPTH.
  function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] base,
                                            input logic [CW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(off);
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return sum[IW-1:0];
  endfunction

  logic          accept;
  logic [IW-1:0] tail_slot;   // slot(count): next push_back target
  logic [IW-1:0] last_slot;   // slot(count-1): current back entry
  logic [IW-1:0] head_dec;    // head-1 with wrap, new head for push_front
  logic [IW-1:0] head_inc;    // head+1 with wrap, new head after pop_front

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign op_ready = op[1] ? !empty : !full;
  assign accept   = op_valid && op_ready;

  assign tail_slot = slot_of(head, count);
  assign last_slot = slot_of(head, count - CW'(1));
  assign head_dec  = (head == '0) ? IW'(DEPTH - 1) : head - IW'(1);
  assign head_inc  = (head == IW'(DEPTH - 1)) ? '0 : head + IW'(1);

  assign front_data = empty ? '0 : mem[head];
  assign back_data  = empty ? '0 : mem[last_slot];

`ifdef HW_DEQUE_PEEK_EN
  assign rd_data = (CW'(rd_idx) < count) ? mem[slot_of(head, CW'(rd_idx))] : '0;
`endif

  // Storage carries no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (op)
        OP_PUSH_BACK:  mem[tail_slot] <= op_data;
        OP_PUSH_FRONT: mem[head_dec]  <= op_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      head      <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        case (op)
          OP_PUSH_BACK: begin
            count <= count + CW'(1);
          end
          OP_PUSH_FRONT: begin
            head  <= head_dec;
            count <= count + CW'(1);
          end
          OP_POP_BACK: begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem[last_slot];
            count     <= count - CW'(1);
          end
          OP_POP_FRONT: begin
            // head is left where it lands when the queue drains; no re-centering.
            rsp_valid <= 1'b1;
            rsp_data  <= mem[head];
            head      <= head_inc;
            count     <= count - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hw_deque.sv
// tb_hw_deque: directed bench for hw_deque. Two instances: DEPTH=8 for the
// queue-method, wrap, stall, reset and back-to-back scenarios, and DEPTH=5
// for fill/overflow on a non-power-of-two buffer. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
module tb_hw_deque;

  localparam int W = 32;

  logic clk;
  logic rst_l;

  // DEPTH=8 instance
  logic          v8, rdy8, rv8, full8, empty8;
  logic [1:0]    o8;
  logic [W-1:0]  d8, rd8, fr8, bk8;
  logic [3:0]    cnt8;
  // DEPTH=5 instance
  logic          v5, rdy5, rv5, full5, empty5;
  logic [1:0]    o5;
  logic [W-1:0]  d5, rd5, fr5, bk5;
  logic [2:0]    cnt5;
`ifdef HW_DEQUE_PEEK_EN
  logic [2:0]    ri8, ri5;
  logic [W-1:0]  pk8, pk5;
`endif

  int vectors;
  int miscompares;

  hw_deque #(.WIDTH(W), .DEPTH(8)) dut8 (
    .clk(clk), .rst_l(rst_l), .op_valid(v8), .op(o8), .op_data(d8),
    .op_ready(rdy8), .rsp_valid(rv8), .rsp_data(rd8), .front_data(fr8),
    .back_data(bk8), .count(cnt8),
`ifdef HW_DEQUE_PEEK_EN
    .rd_idx(ri8), .rd_data(pk8),
`endif
    .full(full8), .empty(empty8)
  );

  hw_deque #(.WIDTH(W), .DEPTH(5)) dut5 (
    .clk(clk), .rst_l(rst_l), .op_valid(v5), .op(o5), .op_data(d5),
    .op_ready(rdy5), .rsp_valid(rv5), .rsp_data(rd5), .front_data(fr5),
    .back_data(bk5), .count(cnt5),
`ifdef HW_DEQUE_PEEK_EN
    .rd_idx(ri5), .rd_data(pk5),
`endif
    .full(full5), .empty(empty5)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    v8 = 1'b0; v5 = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  // Drivers: present one request for one rising edge, then drop valid.
  task automatic op8(input logic [1:0] o, input logic [W-1:0] d);
    @(negedge clk);
    v8 = 1'b1; o8 = o; d8 = d;
    @(posedge clk);
    #1;
    v8 = 1'b0;
  endtask

  task automatic op5(input logic [1:0] o, input logic [W-1:0] d);
    @(negedge clk);
    v5 = 1'b1; o5 = o; d5 = d;
    @(posedge clk);
    #1;
    v5 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    o8 = 2'b00;
    #1;
    vectors++; if (rdy8 !== 1'b1) begin miscompares++; $display("FAIL reset_push_ready got %0b exp 1", rdy8); end
    o8 = 2'b10;
    #1;
    vectors++; if (rdy8 !== 1'b0) begin miscompares++; $display("FAIL reset_pop_ready got %0b exp 0", rdy8); end
    vectors++; if (cnt8 !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", cnt8); end
    vectors++; if (empty8 !== 1'b1 || full8 !== 1'b0) begin miscompares++; $display("FAIL reset_flags got e=%0b f=%0b exp e=1 f=0", empty8, full8); end
    vectors++; if (fr8 !== '0 || bk8 !== '0) begin miscompares++; $display("FAIL reset_ends got %h/%h exp 0/0", fr8, bk8); end
    vectors++; if (rv8 !== 1'b0 || rd8 !== '0) begin miscompares++; $display("FAIL reset_rsp got v=%0b d=%h exp 0/0", rv8, rd8); end
  endtask

  task automatic test_queue_methods();
    do_reset();
    op8(2'b00, 0); op8(2'b00, 2); op8(2'b00, 3); op8(2'b01, 6);
    vectors++; if (fr8 !== 32'd6) begin miscompares++; $display("FAIL qm_front got %0d exp 6", fr8); end
    vectors++; if (bk8 !== 32'd3) begin miscompares++; $display("FAIL qm_back got %0d exp 3", bk8); end
    vectors++; if (cnt8 !== 4'd4) begin miscompares++; $display("FAIL qm_count got %0d exp 4", cnt8); end
    op8(2'b10, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'd3) begin miscompares++; $display("FAIL qm_pop_back got v=%0b d=%0d exp 1/3", rv8, rd8); end
    op8(2'b00, 8);
    vectors++; if (rv8 !== 1'b0 || rd8 !== 32'd3) begin miscompares++; $display("FAIL qm_rsp_hold got v=%0b d=%0d exp 0/3", rv8, rd8); end
    op8(2'b11, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'd6) begin miscompares++; $display("FAIL qm_pop_front got v=%0b d=%0d exp 1/6", rv8, rd8); end
    vectors++; if (fr8 !== 32'd0 || bk8 !== 32'd8 || cnt8 !== 4'd3) begin miscompares++; $display("FAIL qm_final got f=%0d b=%0d c=%0d exp 0/8/3", fr8, bk8, cnt8); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) op5(2'b00, W'(i));
    vectors++; if (full5 !== 1'b1 || cnt5 !== 3'd5) begin miscompares++; $display("FAIL fill_full got f=%0b c=%0d exp 1/5", full5, cnt5); end
    @(negedge clk);
    v5 = 1'b1; o5 = 2'b00; d5 = 32'd6;
    #1;
    vectors++; if (rdy5 !== 1'b0) begin miscompares++; $display("FAIL overflow_ready got %0b exp 0", rdy5); end
    @(posedge clk);
    #1;
    v5 = 1'b0;
    vectors++; if (cnt5 !== 3'd5 || bk5 !== 32'd5) begin miscompares++; $display("FAIL overflow_count got c=%0d b=%0d exp 5/5", cnt5, bk5); end
    for (int i = 1; i <= 5; i++) begin
      op5(2'b11, 0);
      vectors++; if (rv5 !== 1'b1 || rd5 !== W'(i)) begin miscompares++; $display("FAIL drain_%0d got v=%0b d=%0d exp 1/%0d", i, rv5, rd5, i); end
    end
    @(negedge clk);
    o5 = 2'b11;
    #1;
    vectors++; if (empty5 !== 1'b1 || rdy5 !== 1'b0) begin miscompares++; $display("FAIL drain_empty got e=%0b r=%0b exp 1/0", empty5, rdy5); end
  endtask

  task automatic test_wrap();
    do_reset();
    op8(2'b01, 32'hA);
    vectors++; if (dut8.head !== 3'd7 || cnt8 !== 4'd1) begin miscompares++; $display("FAIL wrap_head got h=%0d c=%0d exp 7/1", dut8.head, cnt8); end
    op8(2'b00, 32'hB);
    vectors++; if (bk8 !== 32'hB || fr8 !== 32'hA) begin miscompares++; $display("FAIL wrap_back got b=%h f=%h exp b/a", bk8, fr8); end
    op8(2'b10, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'hB) begin miscompares++; $display("FAIL wrap_pop1 got v=%0b d=%h exp 1/b", rv8, rd8); end
    op8(2'b10, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'hA || empty8 !== 1'b1) begin miscompares++; $display("FAIL wrap_pop2 got v=%0b d=%h e=%0b exp 1/a/1", rv8, rd8, empty8); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    v8 = 1'b1; o8 = 2'b11; d8 = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      vectors++; if (rv8 !== 1'b0 || cnt8 !== 4'd0) begin miscompares++; $display("FAIL stall_cyc%0d got v=%0b c=%0d exp 0/0", c, rv8, cnt8); end
    end
    // A competing push_back takes the port for cycle 4, then the pop resumes.
    @(negedge clk);
    o8 = 2'b00; d8 = 32'd7;
    @(posedge clk);
    #1;
    vectors++; if (cnt8 !== 4'd1 || rv8 !== 1'b0) begin miscompares++; $display("FAIL stall_push got c=%0d v=%0b exp 1/0", cnt8, rv8); end
    @(negedge clk);
    o8 = 2'b11; d8 = '0;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'd7) begin miscompares++; $display("FAIL stall_release got v=%0b d=%0d exp 1/7", rv8, rd8); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) op8(2'b00, W'(i));
    op8(2'b11, 0);
    vectors++; if (cnt8 !== 4'd3 || rv8 !== 1'b1) begin miscompares++; $display("FAIL areset_pre got c=%0d v=%0b exp 3/1", cnt8, rv8); end
    #2;
    rst_l = 1'b0;
    #1;
    vectors++; if (cnt8 !== 4'd0 || empty8 !== 1'b1 || rv8 !== 1'b0) begin miscompares++; $display("FAIL areset_now got c=%0d e=%0b v=%0b exp 0/1/0", cnt8, empty8, rv8); end
    @(negedge clk);
    rst_l = 1'b1;
    op8(2'b00, 32'd9);
    vectors++; if (fr8 !== 32'd9 || bk8 !== 32'd9) begin miscompares++; $display("FAIL areset_after got f=%0d b=%0d exp 9/9", fr8, bk8); end
  endtask

  task automatic test_back_to_back();
    // State on entry: one entry (9). Ops run on consecutive edges.
    op8(2'b00, 32'h11);
    vectors++; if (cnt8 !== 4'd2 || bk8 !== 32'h11) begin miscompares++; $display("FAIL b2b_push got c=%0d b=%h exp 2/11", cnt8, bk8); end
    op8(2'b11, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'd9 || cnt8 !== 4'd1) begin miscompares++; $display("FAIL b2b_popf got v=%0b d=%h c=%0d exp 1/9/1", rv8, rd8, cnt8); end
    op8(2'b01, 32'h22);
    vectors++; if (rv8 !== 1'b0 || fr8 !== 32'h22 || cnt8 !== 4'd2) begin miscompares++; $display("FAIL b2b_pushf got v=%0b f=%h c=%0d exp 0/22/2", rv8, fr8, cnt8); end
    op8(2'b10, 0);
    vectors++; if (rv8 !== 1'b1 || rd8 !== 32'h11 || fr8 !== 32'h22) begin miscompares++; $display("FAIL b2b_popb got v=%0b d=%h f=%h exp 1/11/22", rv8, rd8, fr8); end
  endtask

`ifdef HW_DEQUE_PEEK_EN
  task automatic test_peek();
    do_reset();
    op8(2'b00, 32'd10); op8(2'b00, 32'd20); op8(2'b00, 32'd30);
    ri8 = 3'd1;
    #1;
    vectors++; if (pk8 !== 32'd20) begin miscompares++; $display("FAIL peek_idx1 got %0d exp 20", pk8); end
    ri8 = 3'd3;
    #1;
    vectors++; if (pk8 !== 32'd0) begin miscompares++; $display("FAIL peek_idx3 got %0d exp 0", pk8); end
    op8(2'b01, 32'd5);
    ri8 = 3'd0;
    #1;
    vectors++; if (pk8 !== 32'd5) begin miscompares++; $display("FAIL peek_front got %0d exp 5", pk8); end
    ri8 = 3'd3;
    #1;
    vectors++; if (pk8 !== 32'd30 || cnt8 !== 4'd4) begin miscompares++; $display("FAIL peek_idx3b got d=%0d c=%0d exp 30/4", pk8, cnt8); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_l = 1'b0;
    v8 = 1'b0; o8 = 2'b00; d8 = '0;
    v5 = 1'b0; o5 = 2'b00; d5 = '0;
`ifdef HW_DEQUE_PEEK_EN
    ri8 = '0; ri5 = '0;
`endif
    #12;
    test_reset();
    test_queue_methods();
    test_fill_overflow();
    test_wrap();
    test_stall();
    test_async_reset();
    test_back_to_back();
`ifdef HW_DEQUE_PEEK_EN
    test_peek();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
